// File: rtl/iter_csa_mult_pkg.sv
// mult_pkg: shared types and helpers for the iterative carry-save multiplier.
//   mult_state_t : controller states (IDLE, ITER, RESOLVE, DONE)
//   ceil_div     : integer ceiling division, used to size the iteration count
//   cnt_width    : chunk-counter width, $clog2(NITER+1)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } mult_state_t;

    localparam int MAX_WIDTH = 64;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int cnt_width(input int width, input int bpc);
        return $clog2(ceil_div(width, bpc) + 1);
    endfunction

endpackage

// File: rtl/iter_csa_mult_csa_row.sv
// csa_row: combinational 3:2 compressor over a full product-width row.
//   a, b, c : three addends (current sum, current carry, partial-product row)
//   sum     : bitwise sum
//   carry   : majority bits shifted up one place; the bit shifted out of the
//             top is dropped because the final product fits in W bits
module csa_row #(
    parameter int W = 22
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign maj   = (a & b) | (a & c) | (b & c);
    assign sum   = a ^ b ^ c;
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/iter_csa_mult.sv
// iter_csa_mult: multi-cycle unsigned WIDTH x WIDTH multiplier. BPC multiplier
// bits are retired per cycle into carry-save sum/carry registers, followed by
// one carry-propagate cycle.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (x multiplicand, y multiplier)
//   out_valid/out_ready : result handshake, p = x*y (2*WIDTH bits)
//   busy                : high in ITER or RESOLVE
// Optional build macro ITER_CSA_MULT_EARLY_TERM_EN: leave ITER as soon as the
// unretired multiplier bits are all zero.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// ITER    | retiring BPC multiplier bits per cycle into sum/carry
// RESOLVE | carry-propagate add sum+carry into p
// DONE    | out_valid=1, p held until out_ready
module iter_csa_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int BPC   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int NITER = ceil_div(WIDTH, BPC);
    localparam int YW    = NITER * BPC;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cnt_width(WIDTH, BPC);

    mult_state_t       state, state_d;
    logic [PW-1:0]     mcand_q;
    logic [YW-1:0]     y_q;
    logic [PW-1:0]     sum_q, carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              last_iter;

    // Multiplicand is pre-shifted by BPC each cycle and y shifted down, so
    // row j of the current chunk is always (mcand_q << j) gated by y_q[j].
    logic [BPC:0][PW-1:0] s_ch, c_ch;

    assign s_ch[0] = sum_q;
    assign c_ch[0] = carry_q;

    for (genvar j = 0; j < BPC; j++) begin : g_row
        logic [PW-1:0] pp;
        assign pp = y_q[j] ? (mcand_q << j) : '0;
        csa_row #(.W(PW)) u_csa (
            .a     (s_ch[j]),
            .b     (c_ch[j]),
            .c     (pp),
            .sum   (s_ch[j+1]),
            .carry (c_ch[j+1])
        );
    end

`ifdef ITER_CSA_MULT_EARLY_TERM_EN
    logic [YW-1:0] y_rest;
    assign y_rest    = y_q >> BPC;
    assign last_iter = (cnt_q == CNT_W'(NITER - 1)) || (y_rest == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(NITER - 1));
`endif

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (last_iter) state_d = RESOLVE;
            end
            RESOLVE: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? ITER : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            p       <= '0;
            mcand_q <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                mcand_q <= {{WIDTH{1'b0}}, x};
                y_q     <= YW'(y);
                sum_q   <= '0;
                carry_q <= '0;
                cnt_q   <= '0;
            end else if (state == ITER) begin
                sum_q   <= s_ch[BPC];
                carry_q <= c_ch[BPC];
                mcand_q <= mcand_q << BPC;
                y_q     <= y_q >> BPC;
                cnt_q   <= cnt_q + 1'b1;
            end else if (state == RESOLVE) begin
                p <= sum_q + carry_q;
            end
        end
    end

endmodule

// File: tb/tb_iter_csa_mult.sv
// Directed testbench for iter_csa_mult. Three instances: WIDTH=11/BPC=1,
// WIDTH=24/BPC=5 and WIDTH=11/BPC=4. Latency is counted in edges from the
// accept edge (counted as 1) through the edge at which out_valid rises.
module tb_iter_csa_mult;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

`ifdef ITER_CSA_MULT_EARLY_TERM_EN
    localparam int LAT_Y01 = 3;
`else
    localparam int LAT_Y01 = 13;
`endif

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [10:0] x_a, y_a;
    logic [21:0] p_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [23:0] x_b, y_b;
    logic [47:0] p_b;

    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, busy_c;
    logic [10:0] x_c, y_c;
    logic [21:0] p_c;

    iter_csa_mult #(.WIDTH(11), .BPC(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .x(x_a), .y(y_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .p(p_a), .busy(busy_a));

    iter_csa_mult #(.WIDTH(24), .BPC(5)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .x(x_b), .y(y_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .p(p_b), .busy(busy_b));

    iter_csa_mult #(.WIDTH(11), .BPC(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .x(x_c), .y(y_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .p(p_c), .busy(busy_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge where an accept on dut_a is pending. After the
    // accept edge, in_valid/x/y are replaced by (nv, nx, ny); returns at the
    // negedge where out_valid is first seen high (or the bound expires).
    task automatic wait_a(input logic nv, input logic [10:0] nx, input logic [10:0] ny,
                          output int lat);
        @(negedge clk);
        lat = 1;
        in_valid_a = nv;
        x_a = nx;
        y_a = ny;
        while (!out_valid_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_b(output int lat);
        @(negedge clk);
        lat = 1;
        in_valid_b = 1'b0;
        x_b = 24'h5A5A5A;
        while (!out_valid_b && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_c(output int lat);
        @(negedge clk);
        lat = 1;
        in_valid_c = 1'b0;
        x_c = 11'h2AA;
        while (!out_valid_c && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad;
        logic [10:0] ra, rb;
        logic [23:0] r24a, r24b;

        reset = 1'b1;
        in_valid_a = 0; x_a = 0; y_a = 0; out_ready_a = 1;
        in_valid_b = 0; x_b = 0; y_b = 0; out_ready_b = 1;
        in_valid_c = 0; x_c = 0; y_c = 0; out_ready_c = 1;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_p", p_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_busy_bc", {busy_b, busy_c}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready_a, 1);

        // 0x7FF * 0x7FF, x/y changed during ITER must not matter
        in_valid_a = 1; x_a = 11'h7FF; y_a = 11'h7FF;
        wait_a(0, 11'h123, 11'h456, lat);
        chk("max_p", p_a, 22'h3FF001);
        chk("max_lat", lat, 13);
        @(negedge clk);
        chk("max_ov_one_cycle", out_valid_a, 0);

        // backpressure
        out_ready_a = 0;
        in_valid_a = 1; x_a = 11'h400; y_a = 11'h003;
        wait_a(0, 0, 0, lat);
        chk("bp_p", p_a, 22'h000C00);
        in_valid_a = 1; x_a = 11'h001; y_a = 11'h001;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (p_a !== 22'h000C00 || out_valid_a !== 1'b1 || in_ready_a !== 1'b0) bad++;
        end
        chk("bp_hold", bad, 0);
        out_ready_a = 1;
        #1;
        chk("bp_in_ready_raise", in_ready_a, 1);
        wait_a(0, 0, 0, lat);
        chk("bp_next_p", p_a, 22'h000001);
        chk("bp_next_lat", lat, 13);
        @(negedge clk);

        // back-to-back with in_valid held
        in_valid_a = 1; x_a = 11'd3; y_a = 11'd5;
        wait_a(1, 11'h7FF, 11'h001, lat);
        chk("b2b_p0", p_a, 22'd15);
        chk("b2b_lat0", lat, 13);
        wait_a(0, 0, 0, lat);
        chk("b2b_p1", p_a, 22'h0007FF);
        chk("b2b_lat1", lat, 13);
        @(negedge clk);
        chk("b2b_idle", out_valid_a, 0);

        // reset mid-ITER
        in_valid_a = 1; x_a = 11'h7FF; y_a = 11'h7FF;
        @(negedge clk);
        in_valid_a = 0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy_a, 1);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready_a, 0);
        reset = 0;
        @(negedge clk);
        chk("mid_post_in_ready", in_ready_a, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_a !== 1'b0 || p_a !== 22'd0) bad++;
            @(negedge clk);
        end
        chk("mid_quiet", bad, 0);

        // multiplier-value dependent latency (early termination when built in)
        in_valid_a = 1; x_a = 11'h5A5; y_a = 11'h000;
        wait_a(0, 0, 0, lat);
        chk("y0_p", p_a, 22'd0);
        chk("y0_lat", lat, LAT_Y01);
        @(negedge clk);
        in_valid_a = 1; x_a = 11'h5A5; y_a = 11'h001;
        wait_a(0, 0, 0, lat);
        chk("y1_p", p_a, 22'h0005A5);
        chk("y1_lat", lat, LAT_Y01);
        @(negedge clk);
        in_valid_a = 1; x_a = 11'h5A5; y_a = 11'h400;
        wait_a(0, 0, 0, lat);
        chk("ytop_p", p_a, 22'h169400);
        chk("ytop_lat", lat, 13);
        @(negedge clk);

        // WIDTH=24, BPC=5: NITER=5, top chunk zero-extended
        in_valid_b = 1; x_b = 24'hFFFFFF; y_b = 24'h800001;
        wait_b(lat);
        chk("w24_p", p_b, 48'h8000007FFFFF);
        chk("w24_lat", lat, 7);
        @(negedge clk);
        in_valid_b = 1; x_b = 24'hFFFFFF; y_b = 24'hFFFFFF;
        wait_b(lat);
        chk("w24_max_p", p_b, 48'hFFFFFE000001);
        @(negedge clk);

        // WIDTH=11, BPC=4: NITER=3
        in_valid_c = 1; x_c = 11'h7FF; y_c = 11'h7FF;
        wait_c(lat);
        chk("bpc4_p", p_c, 22'h3FF001);
        chk("bpc4_lat", lat, 5);
        @(negedge clk);

        // random operands against golden product
        for (int i = 0; i < 200; i++) begin
            ra = 11'($urandom_range(0, 2047));
            rb = 11'($urandom_range(0, 2047));
            if (i % 4 == 0) rb = rb >> $urandom_range(0, 10);
            in_valid_a = 1; x_a = ra; y_a = rb;
            wait_a(0, ~ra, ~rb, lat);
            chk("rand_a", p_a, 64'(22'(ra) * 22'(rb)));
            @(negedge clk);
        end
        for (int i = 0; i < 60; i++) begin
            r24a = 24'($urandom);
            r24b = 24'($urandom);
            in_valid_b = 1; x_b = r24a; y_b = r24b;
            wait_b(lat);
            chk("rand_b", p_b, 64'(48'(r24a) * 48'(r24b)));
            @(negedge clk);
            ra = 11'($urandom_range(0, 2047));
            rb = 11'($urandom_range(0, 2047));
            in_valid_c = 1; x_c = ra; y_c = rb;
            wait_c(lat);
            chk("rand_c", p_c, 64'(22'(ra) * 22'(rb)));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
